noc2_msg_collector: RTL and testbench
=====================================

Name: noc2_msg_collector

Overview:
- Downstream consumer of the L2 noc2 output channel: accepts 64-bit flits on a valid/ready handshake, parses the header flit, collects payload flits and presents one decoded message record per packet.
- Decoded type/MSHR fields feed the refinement checker's msg2 comparison; the record also serves as a scoreboard source for L2 benches.
- Holds one message at a time; applies backpressure to the L2 while a record is awaiting consumption.

Parameters:
- MAX_PAYLOAD, 8, number of payload flits stored per message; flits beyond this are accepted and dropped.
- TIMEOUT, 255, idle cycles allowed between flits of one packet before timeout_err is raised.
- CNT_W, 16, width of the msg_count counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- noc_valid  in  1  flit valid from L2 noc2_valid_out
- noc_data  in  64  flit data from L2 noc2_data_out
- noc_ready  out  1  flit accept, drives L2 noc2_ready_out
- msg_valid  out  1  decoded record available
- msg_ready  in  1  consumer accepts record
- msg_type  out  8  header[21:14]
- msg_mshrid  out  8  header[13:6]
- msg_length  out  8  header[29:22], payload flits announced
- msg_dst_x  out  8  header[49:42]
- msg_dst_y  out  8  header[41:34]
- msg_payload  out  64*MAX_PAYLOAD  payload flit i at bits [64*i+63:64*i]; unused slots are zero
- msg_truncated  out  1  msg_length > MAX_PAYLOAD
- msg_count  out  CNT_W  records consumed, wraps modulo 2^CNT_W
- timeout_err  out  1  sticky until rst

Behaviour:
- Reset: state HDR; noc_ready=1; msg_valid=0; every record field = 0; msg_count=0; timeout_err=0.
- A flit transfers when noc_valid && noc_ready on a rising edge.
- HDR state:
  - noc_ready=1.
  - On transfer: latch all header fields and clear the payload store.
  - Load remaining = length, and next state is PAYLOAD if length != 0, otherwise HOLD.
- PAYLOAD state:
  - noc_ready=1.
  - Each transfer writes slot (length - remaining) if that index < MAX_PAYLOAD, else drops the flit, then decrements remaining.
  - The transfer that makes remaining reach 0 moves to HOLD.
- HOLD state:
  - noc_ready=0; msg_valid=1.
  - On msg_ready: msg_count+1, next state HDR, and noc_ready=1 the following cycle.
  - There is no same-cycle bypass between HOLD and a new header.
- Latency:
  - msg_valid rises the cycle after the last flit transfers; for a zero-length packet, the cycle after the header.
  - Minimum packet-to-packet spacing is 1 idle noc_ready cycle.
- Record fields are stable while msg_valid=1 and change only on a header transfer.
- msg_truncated = (msg_length > MAX_PAYLOAD), registered together with the header.
- Timeout:
  - An idle counter runs only in PAYLOAD; it clears on each transfer and saturates at TIMEOUT.
  - Reaching TIMEOUT sets timeout_err and forces state HDR, discarding the partial packet. No msg_valid is produced for it.
- msg_ready while msg_valid=0 is ignored.
- noc_valid while noc_ready=0 is not a transfer; the flit must be held by the L2.
- msg_count wraps from 2^CNT_W-1 to 0.
- rst mid-packet or in HOLD: the partial packet or unconsumed record is discarded and all reset values apply on the next cycle.

Decomposition:
- Shared package noc_msg_pkg holds:
  - header field bit-position constants (LENGTH 29:22, TYPE 21:14, MSHRID 13:6, DST_X 49:42, DST_Y 41:34, CHIPID 63:50);
  - the state enum {HDR, PAYLOAD, HOLD};
  - L2 message-type constants used by the checker (e.g. data-ack, invalidation).
- One natural sub-module: noc_hdr_decode, a combinational field extractor from a 64-bit header. It is reused by the noc1/noc3 stimulus side.
- FSM, payload store and counters stay in the top module.

Test Plan:
- Header with type=0x0C, mshrid=0x05, len=0, msg_ready=1 -> msg_valid=1 one cycle later, fields match, payload=0, msg_count=1, noc_ready back to 1 the next cycle.
- Header len=2 then flits 0xAAAA..., 0x5555... back-to-back -> msg_valid the cycle after the 2nd flit, slot0=0xAAAA..., slot1=0x5555..., truncated=0.
- Header len=10 with MAX_PAYLOAD=8 and 10 payload flits -> all 11 flits accepted, slots 0-7 hold flits 1-8, truncated=1.
- msg_ready held 0 for 5 cycles in HOLD while noc_valid=1 -> noc_ready=0 throughout, record stable, msg_count unchanged until msg_ready pulses.
- Header len=3, one payload flit, then 255 idle cycles -> timeout_err=1, state HDR, no msg_valid; next packet decodes correctly with timeout_err still 1.
- rst asserted after 1 of 4 payload flits, then a new len=0 packet -> only the new packet produces a record, msg_count=1.

Source files
------------

// File: rtl/noc_msg_pkg.sv
// ============================================================================
// noc_msg_pkg : shared noc2 header layout, collector states, L2 message types
// Revision    : 1.0
// ============================================================================
`default_nettype none

package noc_msg_pkg;

    localparam int HDR_CHIPID_MSB  = 63;
    localparam int HDR_CHIPID_LSB  = 50;
    localparam int HDR_DST_X_MSB   = 49;
    localparam int HDR_DST_X_LSB   = 42;
    localparam int HDR_DST_Y_MSB   = 41;
    localparam int HDR_DST_Y_LSB   = 34;
    localparam int HDR_RSVD_HI_MSB = 33;
    localparam int HDR_RSVD_HI_LSB = 30;
    localparam int HDR_LENGTH_MSB  = 29;
    localparam int HDR_LENGTH_LSB  = 22;
    localparam int HDR_TYPE_MSB    = 21;
    localparam int HDR_TYPE_LSB    = 14;
    localparam int HDR_MSHRID_MSB  = 13;
    localparam int HDR_MSHRID_LSB  = 6;
    localparam int HDR_RSVD_LO_MSB = 5;
    localparam int HDR_RSVD_LO_LSB = 0;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HOLD    = 2'd2
    } state_e;

    // L2 -> core message types compared by the refinement checker
    localparam logic [7:0] MSG_TYPE_DATA_ACK    = 8'd12;
    localparam logic [7:0] MSG_TYPE_NODATA_ACK  = 8'd13;
    localparam logic [7:0] MSG_TYPE_INV_FWD     = 8'd17;
    localparam logic [7:0] MSG_TYPE_INV_FWDACK  = 8'd21;

    typedef struct packed {
        logic [13:0] chipid;
        logic [7:0]  dst_x;
        logic [7:0]  dst_y;
        logic [3:0]  rsvd_hi;
        logic [7:0]  length;
        logic [7:0]  mtype;
        logic [7:0]  mshrid;
        logic [5:0]  rsvd_lo;
    } hdr_fields_t;

endpackage

`default_nettype wire

// File: rtl/noc_hdr_decode.sv
// ============================================================================
// noc_hdr_decode : combinational field extractor for a 64-bit noc header flit
// Revision       : 1.0
// ============================================================================
`default_nettype none

module noc_hdr_decode
    import noc_msg_pkg::*;
(
    input  logic [63:0] hdr_i,
    output hdr_fields_t fields_o
);

    always_comb begin
        fields_o         = '0;
        fields_o.chipid  = hdr_i[HDR_CHIPID_MSB:HDR_CHIPID_LSB];
        fields_o.dst_x   = hdr_i[HDR_DST_X_MSB:HDR_DST_X_LSB];
        fields_o.dst_y   = hdr_i[HDR_DST_Y_MSB:HDR_DST_Y_LSB];
        fields_o.rsvd_hi = hdr_i[HDR_RSVD_HI_MSB:HDR_RSVD_HI_LSB];
        fields_o.length  = hdr_i[HDR_LENGTH_MSB:HDR_LENGTH_LSB];
        fields_o.mtype   = hdr_i[HDR_TYPE_MSB:HDR_TYPE_LSB];
        fields_o.mshrid  = hdr_i[HDR_MSHRID_MSB:HDR_MSHRID_LSB];
        fields_o.rsvd_lo = hdr_i[HDR_RSVD_LO_MSB:HDR_RSVD_LO_LSB];
    end

endmodule

`default_nettype wire

// File: rtl/noc2_msg_collector.sv
// ============================================================================
// noc2_msg_collector : collects one noc2 packet into a decoded message record
// Revision           : 1.0
// ============================================================================
`default_nettype none

module noc2_msg_collector
    import noc_msg_pkg::*;
#(
    parameter int MAX_PAYLOAD = 8,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      noc_valid,
    input  logic [63:0]               noc_data,
    output logic                      noc_ready,
    output logic                      msg_valid,
    input  logic                      msg_ready,
    output logic [7:0]                msg_type,
    output logic [7:0]                msg_mshrid,
    output logic [7:0]                msg_length,
    output logic [7:0]                msg_dst_x,
    output logic [7:0]                msg_dst_y,
    output logic [64*MAX_PAYLOAD-1:0] msg_payload,
    output logic                      msg_truncated,
    output logic [CNT_W-1:0]          msg_count,
    output logic                      timeout_err
);

    localparam int               IDLE_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [8:0]        MAX_PL   = 9'(MAX_PAYLOAD);

    state_e            state_q, state_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [7:0]        type_q, type_d;
    logic [7:0]        mshrid_q, mshrid_d;
    logic [7:0]        length_q, length_d;
    logic [7:0]        dst_x_q, dst_x_d;
    logic [7:0]        dst_y_q, dst_y_d;
    logic              trunc_q, trunc_d;
    logic [63:0]       payload_q [MAX_PAYLOAD];
    logic [63:0]       payload_d [MAX_PAYLOAD];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;

    hdr_fields_t       w_hdr;
    logic              w_xfer;
    logic [7:0]        w_slot;
    logic              w_slot_ok;
    logic [IDLE_W-1:0] w_idle_inc;
    logic              w_unused_hdr;

    noc_hdr_decode u_hdr_decode (
        .hdr_i    (noc_data),
        .fields_o (w_hdr)
    );

    assign w_unused_hdr = ^{w_hdr.chipid, w_hdr.rsvd_hi, w_hdr.rsvd_lo};

    assign noc_ready  = (state_q != ST_HOLD);
    assign msg_valid  = (state_q == ST_HOLD);
    assign w_xfer     = noc_valid && noc_ready;
    assign w_slot     = length_q - remaining_q;
    assign w_slot_ok  = ({1'b0, w_slot} < MAX_PL);
    assign w_idle_inc = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        idle_d      = '0;
        type_d      = type_q;
        mshrid_d    = mshrid_q;
        length_d    = length_q;
        dst_x_d     = dst_x_q;
        dst_y_d     = dst_y_q;
        trunc_d     = trunc_q;
        payload_d   = payload_q;
        count_d     = count_q;
        err_d       = err_q;

        case (state_q)
            ST_HDR: begin
                if (w_xfer) begin
                    type_d      = w_hdr.mtype;
                    mshrid_d    = w_hdr.mshrid;
                    length_d    = w_hdr.length;
                    dst_x_d     = w_hdr.dst_x;
                    dst_y_d     = w_hdr.dst_y;
                    trunc_d     = ({1'b0, w_hdr.length} > MAX_PL);
                    remaining_d = w_hdr.length;
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        payload_d[i] = '0;
                    end
                    state_d = (w_hdr.length != 8'd0) ? ST_PAYLOAD : ST_HOLD;
                end
            end
            ST_PAYLOAD: begin
                if (w_xfer) begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (w_slot_ok && (w_slot == 8'(i))) begin
                            payload_d[i] = noc_data;
                        end
                    end
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = ST_HOLD;
                    end
                end else if (w_idle_inc == IDLE_MAX) begin
                    // Stalled packet: abandon it, the record keeps its last value
                    err_d   = 1'b1;
                    state_d = ST_HDR;
                end else begin
                    idle_d = w_idle_inc;
                end
            end
            ST_HOLD: begin
                if (msg_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HDR;
            remaining_q <= '0;
            idle_q      <= '0;
            type_q      <= '0;
            mshrid_q    <= '0;
            length_q    <= '0;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            trunc_q     <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                payload_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            idle_q      <= idle_d;
            type_q      <= type_d;
            mshrid_q    <= mshrid_d;
            length_q    <= length_d;
            dst_x_q     <= dst_x_d;
            dst_y_q     <= dst_y_d;
            trunc_q     <= trunc_d;
            count_q     <= count_d;
            err_q       <= err_d;
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                payload_q[i] <= payload_d[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_payload
            assign msg_payload[64*gi +: 64] = payload_q[gi];
        end
    endgenerate

    assign msg_type      = type_q;
    assign msg_mshrid    = mshrid_q;
    assign msg_length    = length_q;
    assign msg_dst_x     = dst_x_q;
    assign msg_dst_y     = dst_y_q;
    assign msg_truncated = trunc_q;
    assign msg_count     = count_q;
    assign timeout_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_noc2_msg_collector.sv
// ============================================================================
// tb_noc2_msg_collector : scoreboard bench for the noc2 message collector
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_noc2_msg_collector;

    localparam int MAXP = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 noc_valid;
    logic [63:0]          noc_data;
    logic                 noc_ready;
    logic                 msg_valid;
    logic                 msg_ready;
    logic [7:0]           msg_type;
    logic [7:0]           msg_mshrid;
    logic [7:0]           msg_length;
    logic [7:0]           msg_dst_x;
    logic [7:0]           msg_dst_y;
    logic [64*MAXP-1:0]   msg_payload;
    logic                 msg_truncated;
    logic [15:0]          msg_count;
    logic                 timeout_err;

    always #5 clk = ~clk;

    noc2_msg_collector #(
        .MAX_PAYLOAD (MAXP),
        .TIMEOUT     (255),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .noc_valid     (noc_valid),
        .noc_data      (noc_data),
        .noc_ready     (noc_ready),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .msg_type      (msg_type),
        .msg_mshrid    (msg_mshrid),
        .msg_length    (msg_length),
        .msg_dst_x     (msg_dst_x),
        .msg_dst_y     (msg_dst_y),
        .msg_payload   (msg_payload),
        .msg_truncated (msg_truncated),
        .msg_count     (msg_count),
        .timeout_err   (timeout_err)
    );

    typedef struct packed {
        logic [7:0]             typ;
        logic [7:0]             mshr;
        logic [7:0]             len;
        logic [7:0]             dx;
        logic [7:0]             dy;
        logic                   trunc;
        logic [MAXP-1:0][63:0]  pl;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        mon_e;
    logic        mv_prev = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] pl_buf [16];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [7:0] typ, input logic [7:0] mshr,
                                          input logic [7:0] dx, input logic [7:0] dy,
                                          input logic [7:0] len);
        return {14'h2A5, dx, dy, 4'hF, len, typ, mshr, 6'h15};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [63:0] d);
        int n = 0;
        noc_valid = 1'b1;
        noc_data  = d;
        while (!noc_ready && n < 300) begin
            tick();
            n++;
        end
        if (n == 300) check_eq("flit_wait_timeout", 64'(noc_ready), 64'd1);
        tick();
        noc_valid = 1'b0;
        noc_data  = 64'hDEAD_BEEF_0BAD_F00D;
    endtask

    task automatic send_packet(input logic [7:0] typ, input logic [7:0] mshr,
                               input logic [7:0] dx, input logic [7:0] dy,
                               input logic [7:0] len, input int nflits, input bit expect_rec);
        rec_t r;
        r       = '0;
        r.typ   = typ;
        r.mshr  = mshr;
        r.len   = len;
        r.dx    = dx;
        r.dy    = dy;
        r.trunc = (int'(len) > MAXP);
        for (int k = 0; k < MAXP; k++) begin
            if (k < int'(len) && k < nflits) r.pl[k] = pl_buf[k];
        end
        if (expect_rec) exp_q.push_back(r);
        send_flit(mk_hdr(typ, mshr, dx, dy, len));
        for (int k = 0; k < nflits; k++) begin
            send_flit(pl_buf[k]);
        end
    endtask

    // Scoreboard: every rising msg_valid must match the oldest expected record
    always @(negedge clk) begin
        if (rst) begin
            mv_prev = 1'b0;
        end else begin
            if (msg_valid && !mv_prev) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_record", 64'(msg_valid), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("rec_type",   64'(msg_type),      64'(mon_e.typ));
                    check_eq("rec_mshrid", 64'(msg_mshrid),    64'(mon_e.mshr));
                    check_eq("rec_length", 64'(msg_length),    64'(mon_e.len));
                    check_eq("rec_dst_x",  64'(msg_dst_x),     64'(mon_e.dx));
                    check_eq("rec_dst_y",  64'(msg_dst_y),     64'(mon_e.dy));
                    check_eq("rec_trunc",  64'(msg_truncated), 64'(mon_e.trunc));
                    for (int k = 0; k < MAXP; k++) begin
                        check_eq($sformatf("rec_slot%0d", k), msg_payload[64*k +: 64], mon_e.pl[k]);
                    end
                end
            end
            mv_prev = msg_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        noc_valid = 1'b0;
        noc_data  = '0;
        msg_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        check_eq("rst_noc_ready", 64'(noc_ready),      64'd1);
        check_eq("rst_msg_valid", 64'(msg_valid),      64'd0);
        check_eq("rst_type",      64'(msg_type),       64'd0);
        check_eq("rst_length",    64'(msg_length),     64'd0);
        check_eq("rst_payload",   64'(|msg_payload),   64'd0);
        check_eq("rst_trunc",     64'(msg_truncated),  64'd0);
        check_eq("rst_count",     64'(msg_count),      64'd0);
        check_eq("rst_err",       64'(timeout_err),    64'd0);

        // zero-length packet, consumer always ready
        msg_ready = 1'b1;
        send_packet(8'h0C, 8'h05, 8'h03, 8'h04, 8'd0, 0, 1'b1);
        check_eq("t1_valid",     64'(msg_valid), 64'd1);
        check_eq("t1_noc_ready", 64'(noc_ready), 64'd0);
        check_eq("t1_count0",    64'(msg_count), 64'd0);
        tick();
        check_eq("t1_valid_drop", 64'(msg_valid), 64'd0);
        check_eq("t1_noc_ready1", 64'(noc_ready), 64'd1);
        check_eq("t1_count1",     64'(msg_count), 64'd1);

        // two back-to-back payload flits
        pl_buf[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        pl_buf[1] = 64'h5555_5555_5555_5555;
        send_packet(8'h0D, 8'h11, 8'h01, 8'h02, 8'd2, 2, 1'b1);
        check_eq("t2_valid", 64'(msg_valid),     64'd1);
        check_eq("t2_trunc", 64'(msg_truncated), 64'd0);
        tick();
        check_eq("t2_count", 64'(msg_count), 64'd2);

        // over-long packet: flits past the store are accepted and dropped
        for (int k = 0; k < 16; k++) pl_buf[k] = 64'h1111_0000_0000_0000 + 64'(k * 3 + 1);
        send_packet(8'h14, 8'h22, 8'h05, 8'h06, 8'd10, 10, 1'b1);
        check_eq("t3_valid", 64'(msg_valid),     64'd1);
        check_eq("t3_trunc", 64'(msg_truncated), 64'd1);
        tick();
        check_eq("t3_count", 64'(msg_count), 64'd3);

        // backpressure while record held
        msg_ready = 1'b0;
        pl_buf[0] = 64'hFEED_FACE_CAFE_0001;
        send_packet(8'h0C, 8'h33, 8'h07, 8'h08, 8'd1, 1, 1'b1);
        check_eq("t4_valid", 64'(msg_valid), 64'd1);
        noc_valid = 1'b1;
        noc_data  = mk_hdr(8'h11, 8'h44, 8'h09, 8'h0A, 8'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("t4_hold_noc_ready", 64'(noc_ready),            64'd0);
            check_eq("t4_hold_valid",     64'(msg_valid),            64'd1);
            check_eq("t4_hold_mshrid",    64'(msg_mshrid),           64'h33);
            check_eq("t4_hold_slot0",     msg_payload[63:0],         64'hFEED_FACE_CAFE_0001);
            check_eq("t4_hold_count",     64'(msg_count),            64'd3);
        end
        msg_ready = 1'b1;
        send_packet(8'h11, 8'h44, 8'h09, 8'h0A, 8'd0, 0, 1'b1);
        check_eq("t4_next_valid", 64'(msg_valid), 64'd1);
        check_eq("t4_next_type",  64'(msg_type),  64'h11);
        check_eq("t4_count_mid",  64'(msg_count), 64'd4);
        tick();
        check_eq("t4_count", 64'(msg_count), 64'd5);

        // stalled packet times out and is discarded
        pl_buf[0] = 64'h0123_4567_89AB_CDEF;
        send_packet(8'h0C, 8'h55, 8'h01, 8'h01, 8'd3, 1, 1'b0);
        repeat (254) tick();
        check_eq("t5_err_early",  64'(timeout_err), 64'd0);
        check_eq("t5_busy_ready", 64'(noc_ready),   64'd1);
        tick();
        check_eq("t5_err",       64'(timeout_err), 64'd1);
        check_eq("t5_noc_ready", 64'(noc_ready),   64'd1);
        check_eq("t5_no_valid",  64'(msg_valid),   64'd0);
        pl_buf[0] = 64'h7777_8888_9999_AAAA;
        send_packet(8'h0D, 8'h66, 8'h02, 8'h03, 8'd1, 1, 1'b1);
        check_eq("t5_next_valid", 64'(msg_valid), 64'd1);
        tick();
        check_eq("t5_count",      64'(msg_count),   64'd6);
        check_eq("t5_err_sticky", 64'(timeout_err), 64'd1);

        // reset in the middle of a packet
        pl_buf[0] = 64'hBBBB_0000_CCCC_1111;
        send_packet(8'h0C, 8'h77, 8'h04, 8'h04, 8'd4, 1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_count0",    64'(msg_count),   64'd0);
        check_eq("t6_err0",      64'(timeout_err), 64'd0);
        check_eq("t6_valid0",    64'(msg_valid),   64'd0);
        check_eq("t6_type0",     64'(msg_type),    64'd0);
        check_eq("t6_noc_ready", 64'(noc_ready),   64'd1);
        send_packet(8'h0C, 8'h05, 8'h01, 8'h01, 8'd0, 0, 1'b1);
        check_eq("t6_valid", 64'(msg_valid), 64'd1);
        tick();
        check_eq("t6_count1", 64'(msg_count), 64'd1);

        repeat (3) tick();
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
